// File: rtl/dct_mac_seq.sv
// Sequencer for a DCT multiply-accumulate unit: N_TAPS samples per result, MUL_LAT drain, then result hold.
// Define DCT_SEQ_PERF_CNT_EN to add the stall_cnt result back-pressure counter.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for the first sample of a block (accept clears the MAC)
// S_ACC   | accumulating samples, cnt selects the coefficient
// S_DRAIN | waiting MUL_LAT cycles for the MAC pipeline to settle
// S_HOLD  | result valid, waiting for the downstream handshake
module dct_mac_seq #(
    parameter int N_TAPS  = 8,
    parameter int MUL_LAT = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic [$clog2(N_TAPS)-1:0]   coef_sel,
    output logic                        mac_clr,
    output logic                        mac_en,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        busy
`ifdef DCT_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]                 stall_cnt
`endif
);

    localparam int CW = $clog2(N_TAPS);
    localparam logic [CW-1:0] LAST_TAP  = CW'(N_TAPS - 1);
    localparam logic [1:0]    DRAIN_LD  = 2'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [1:0]      r_dcnt;
    logic [1:0]      w_dcnt_nxt;

    logic            w_run;
    logic            w_accept;
    logic            w_in_hold;

    // Outputs are gated by rst as well so din_ready reads 0 while reset is held.
    assign w_run     = ena & rst;
    assign w_in_hold = (r_state == S_HOLD);

    assign din_ready = w_run & ((r_state == S_IDLE) | (r_state == S_ACC));
    assign w_accept  = din_valid & din_ready;
    assign mac_en    = w_accept;
    assign mac_clr   = w_accept & (r_state == S_IDLE);
    assign coef_sel  = w_run ? r_cnt : '0;
    assign res_valid = w_run & w_in_hold;
    assign busy      = w_run & (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dcnt_nxt  = r_dcnt;
        if (w_run) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = S_ACC;
                        w_cnt_nxt   = CW'(1);
                    end
                end
                S_ACC: begin
                    if (w_accept) begin
                        if (r_cnt == LAST_TAP) begin
                            w_state_nxt = S_DRAIN;
                            w_cnt_nxt   = '0;
                            w_dcnt_nxt  = DRAIN_LD;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_dcnt == 2'd0) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_dcnt_nxt = r_dcnt - 2'd1;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_dcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

`ifdef DCT_SEQ_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ena & w_in_hold & ~res_ready;

    // Saturating; only reset clears it so software can read it at leisure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = w_run ? r_stall_cnt : '0;
`endif

endmodule

// File: tb/tb_dct_mac_seq.sv
// Self-checking bench for dct_mac_seq: per-cycle compare against a block-progress model plus directed scenarios.
module tb_dct_mac_seq;

    localparam int N = 8;
    localparam int M = 2;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       din_valid;
    logic       din_ready;
    logic [2:0] coef_sel;
    logic       mac_clr;
    logic       mac_en;
    logic       res_valid;
    logic       res_ready;
    logic       busy;
    logic [15:0] stall_cnt;

    dct_mac_seq #(.N_TAPS(N), .MUL_LAT(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .coef_sel  (coef_sel),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
`ifdef DCT_SEQ_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

`ifndef DCT_SEQ_PERF_CNT_EN
    assign stall_cnt = 16'd0;
`endif

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: a block is "m_taps samples taken so far"; once all N are in,
    // m_since counts cycles since the last sample and the result shows at M.
    int m_taps;
    int m_since;
    int m_stall;
    bit chk_on = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_taps  <= 0;
            m_since <= 0;
            m_stall <= 0;
        end else if (ena) begin
            if (m_taps < N && din_valid) begin
                m_taps  <= m_taps + 1;
                m_since <= 0;
            end else if (m_taps == N) begin
                if (m_since < M) m_since <= m_since + 1;
                else if (res_ready) m_taps <= 0;
                else if (m_stall < 65535) m_stall <= m_stall + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            bit live, e_ready, e_acc;
            live    = ena && rst;
            e_ready = live && (m_taps < N);
            e_acc   = e_ready && din_valid;
            chk("cyc_din_ready", din_ready, e_ready);
            chk("cyc_mac_en",    mac_en,    e_acc);
            chk("cyc_mac_clr",   mac_clr,   e_acc && (m_taps == 0));
            chk("cyc_coef_sel",  coef_sel,  (live && m_taps < N) ? m_taps : 0);
            chk("cyc_res_valid", res_valid, live && m_taps == N && m_since == M);
            chk("cyc_busy",      busy,      live && m_taps != 0);
`ifdef DCT_SEQ_PERF_CNT_EN
            chk("cyc_stall_cnt", stall_cnt, live ? m_stall : 0);
`endif
        end
    end

    int tcyc = 0;
    logic s_ready, s_en, s_clr, s_rv, s_busy;
    logic [2:0] s_sel;

    task automatic tick();
        @(negedge clk);
        tcyc++;
        s_ready = din_ready; s_en = mac_en; s_clr = mac_clr;
        s_sel = coef_sel; s_rv = res_valid; s_busy = busy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; ena = 1'b1; din_valid = 1'b0; res_ready = 1'b0;
        #1;
        chk("rst_din_ready", din_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_coef_sel", coef_sel, 0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, lowc, rvc, last8, c, stalls;
        rst = 1'b0; ena = 1'b0; din_valid = 1'b0; res_ready = 1'b0;
        #2;
        chk_on = 1;

        // Back-to-back stream
        do_reset();
        din_valid = 1; res_ready = 1;
        k = 0; lowc = 0; rvc = 0; last8 = -100;
        for (c = 0; c < 100 && k < 24; c++) begin
            tick();
            if (!s_ready) lowc++;
            if (s_rv) begin rvc++; chk("b2b_latency", tcyc - last8, 3); end
            if (s_en) begin
                chk("b2b_clr", s_clr, (k % 8) == 0);
                chk("b2b_sel", s_sel, k % 8);
                if (k % 8 == 7) last8 = tcyc;
                k++;
            end
        end
        chk("b2b_accepts", k, 24);
        chk("b2b_results", rvc, 2);
        chk("b2b_ready_low", lowc, 6);

        // Bubbles after sample 3
        do_reset();
        din_valid = 1; res_ready = 1; k = 0;
        for (c = 0; c < 50 && k < 4; c++) begin tick(); if (s_en) k++; end
        din_valid = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bub_sel_hold", s_sel, 4);
            chk("bub_no_en", s_en, 0);
        end
        din_valid = 1;
        for (c = 0; c < 50 && k < 8; c++) begin tick(); if (s_en) begin k++; last8 = tcyc; end end
        din_valid = 0; rvc = 0;
        for (c = 0; c < 20 && rvc == 0; c++) begin
            tick();
            if (s_en) k++;
            if (s_rv) begin rvc = 1; chk("bub_latency", tcyc - last8, 3); end
        end
        chk("bub_accepts", k, 8);
        chk("bub_result", rvc, 1);

        // Back-pressure in HOLD
        do_reset();
        din_valid = 1; res_ready = 0; rvc = 0;
        for (c = 0; c < 50 && rvc == 0; c++) begin tick(); if (s_rv) rvc = 1; end
        chk("bp_reach_hold", rvc, 1);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("bp_rv_high", s_rv, 1);
            chk("bp_ready_low", s_ready, 0);
            chk("bp_no_en", s_en, 0);
        end
`ifdef DCT_SEQ_PERF_CNT_EN
        chk("bp_stall_cnt", stall_cnt, 10);
`endif
        res_ready = 1;
        tick();
        chk("bp_handshake", s_rv, 1);
        tick();
        chk("bp_next_en", s_en, 1);
        chk("bp_next_clr", s_clr, 1);
        chk("bp_next_sel", s_sel, 0);

        // ena gating mid-ACC
        do_reset();
        din_valid = 1; res_ready = 1; k = 0;
        for (c = 0; c < 50 && k < 5; c++) begin tick(); if (s_en) k++; end
        ena = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ena_outs_zero", {s_ready, s_en, s_clr, s_rv, s_busy, s_sel}, 0);
        end
        ena = 1;
        tick();
        chk("ena_resume_sel", s_sel, 5);
        if (s_en) k++;
        rvc = 0;
        for (c = 0; c < 30 && rvc == 0; c++) begin
            tick();
            if (s_en) k++;
            if (s_rv) rvc = 1;
        end
        chk("ena_result", rvc, 1);
        chk("ena_accepts", k, 8);

        // Reset mid-DRAIN
        do_reset();
        din_valid = 1; res_ready = 1; k = 0;
        for (c = 0; c < 50 && k < 8; c++) begin tick(); if (s_en) k++; end
        chk("rd_busy_before", busy, 1);
        rst = 0;
        #1;
        chk("rd_busy_async", busy, 0);
        chk("rd_rv_async", res_valid, 0);
        tick();
        rst = 1; din_valid = 0; rvc = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (s_rv) rvc++; end
        chk("rd_no_result", rvc, 0);
        din_valid = 1;
        tick();
        chk("rd_next_en", s_en, 1);
        chk("rd_next_clr", s_clr, 1);
        chk("rd_next_sel", s_sel, 0);

`ifdef DCT_SEQ_PERF_CNT_EN
        // Stall counter saturation
        do_reset();
        din_valid = 1; res_ready = 0; rvc = 0;
        for (c = 0; c < 50 && rvc == 0; c++) begin tick(); if (s_rv) rvc = 1; end
        for (int i = 0; i < 70000; i++) tick();
        chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
        res_ready = 1;
        tick();
        chk("sat_hold_cnt", stall_cnt, 16'hFFFF);
`endif

        // Random traffic
        do_reset();
        stalls = 0;
        for (int i = 0; i < 3000; i++) begin
            ena       = ($urandom_range(0, 9) != 0);
            din_valid = ($urandom_range(0, 9) < 7);
            res_ready = ($urandom_range(0, 1) == 1);
            rst       = ($urandom_range(0, 199) != 0);
            tick();
            if (s_rv) stalls++;
        end
        rst = 1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
